// File: rtl/vid_pixel_pipe_if.sv
// vid_pixel_pipe_if: pixel write channel between the bus fetch logic and the display FIFO
interface vid_pixel_pipe_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                          wr_valid;
    logic [31:0]                   wr_data;
    logic                          wr_ready;
    logic                          fetch_req;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    modport master (output wr_valid, wr_data, input wr_ready, fetch_req, fifo_level);
    modport slave  (input wr_valid, wr_data, output wr_ready, fetch_req, fifo_level);
endinterface

// File: rtl/vid_pixel_pipe.sv
// vid_pixel_pipe: pixel FIFO plus raster timing generator driving registered sync/blank and RGB
module vid_pixel_pipe #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    vid_pixel_pipe_if.slave wr,
    output logic            frame_start,
    output logic            underflow,
    output logic            hsync,
    output logic            hblank,
    output logic            vsync,
    output logic            vblank,
    output logic [7:0]      R,
    output logic [7:0]      G,
    output logic [7:0]      B
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [LW-1:0] FULL   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LOW    = LW'(LOW_WATER);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          underflow_q, underflow_d;
    logic          frame_start_q, frame_start_d;
    logic          hsync_q, hsync_d, hblank_q, hblank_d;
    logic          vsync_q, vsync_d, vblank_q, vblank_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic          active, push, pop;
    logic          unused_hi;

    assign unused_hi     = ^wr.wr_data[31:24];
    assign wr.wr_ready   = enable && (level_q != FULL);
    assign wr.fetch_req  = enable && (level_q < LOW);
    assign wr.fifo_level = level_q;
    assign frame_start   = frame_start_q;
    assign underflow     = underflow_q;
    assign hsync         = hsync_q;
    assign hblank        = hblank_q;
    assign vsync         = vsync_q;
    assign vblank        = vblank_q;
    assign {R, G, B}     = rgb_q;

    // Next raster position, FIFO bookkeeping and the outputs for the current position; disable forces idle
    always_comb begin
        active        = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        push          = wr.wr_valid && wr.wr_ready;
        pop           = enable && active && (level_q != '0);
        hcnt_d        = (!enable || hcnt_q == H_LAST) ? '0 : hcnt_q + HW'(1);
        vcnt_d        = !enable ? '0 : (hcnt_q != H_LAST) ? vcnt_q : (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        wr_ptr_d      = !enable ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d      = !enable ? '0 : rd_ptr_q + AW'(pop);
        level_d       = !enable ? '0 : level_q + LW'(push) - LW'(pop);
        underflow_d   = enable && (underflow_q || (active && level_q == '0));
        frame_start_d = enable && (hcnt_q == '0) && (vcnt_q == '0);
        hblank_d      = enable && (hcnt_q >= H_ACT);
        hsync_d       = enable && (hcnt_q >= H_SS) && (hcnt_q < H_SE);
        vblank_d      = enable && (vcnt_q >= V_ACT);
        vsync_d       = enable && (vcnt_q >= V_SS) && (vcnt_q < V_SE);
        rgb_d         = pop ? mem_q[rd_ptr_q] : '0;
    end

    // State and output registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            underflow_q   <= 1'b0;
            frame_start_q <= 1'b0;
            hblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vblank_q      <= 1'b0;
            vsync_q       <= 1'b0;
            rgb_q         <= '0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            underflow_q   <= underflow_d;
            frame_start_q <= frame_start_d;
            hblank_q      <= hblank_d;
            hsync_q       <= hsync_d;
            vblank_q      <= vblank_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
        end
    end

    // Pixel storage; only the 24 colour bits are kept
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr.wr_data[23:0];
    end
endmodule

// File: tb/tb_vid_pixel_pipe.sv
// tb_vid_pixel_pipe: directed checks of raster timing, FIFO flow, underflow and idle behaviour
module tb_vid_pixel_pipe;
    logic clk, reset, enable;
    logic frame_start, underflow, hsync, hblank, vsync, vblank;
    logic [7:0] R, G, B;
    logic [5:0] flags;
    logic [23:0] rgb;
    int t, n_pass, n_tot, j, k;
    bit auto_chk;
    logic [31:0] w [4];

    vid_pixel_pipe_if #(.FIFO_DEPTH(4)) wr_if ();

    vid_pixel_pipe #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FIFO_DEPTH(4), .LOW_WATER(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr(wr_if),
        .frame_start(frame_start), .underflow(underflow),
        .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
        .R(R), .G(G), .B(B)
    );

    assign flags = {frame_start, underflow, hsync, hblank, vsync, vblank};
    assign rgb   = {R, G, B};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
        else n_pass++;
    endtask

    function automatic logic [5:0] exp_flags(input int p);
        int h, v;
        h = p % 8;
        v = (p / 8) % 6;
        return {h == 0 && v == 0, 1'b1, h == 5 || h == 6, h >= 4, v == 4, v >= 3};
    endfunction

    function automatic bit is_act(input int p);
        return (p % 8) < 4 && ((p / 8) % 6) < 3;
    endfunction

    function automatic logic [31:0] dword(input int i);
        return {8'(i + 1), 24'h102030 + 24'(i) * 24'h010101};
    endfunction

    task automatic tick();
        @(negedge clk);
        t++;
        if (auto_chk) begin
            chk("timing", 32'(flags), 32'(exp_flags(t)));
            if (!is_act(t)) chk("blank_rgb", 32'(rgb), 32'h0);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out"}, 32'({flags, wr_if.wr_ready, wr_if.fetch_req}), 32'h0);
        chk({tag, "_rgb"}, 32'(rgb), 32'h0);
        chk({tag, "_lvl"}, 32'(wr_if.fifo_level), 32'h0);
    endtask

    initial begin
        n_pass = 0; n_tot = 0; t = 0; auto_chk = 0;
        w[0] = 32'h00112233; w[1] = 32'h00445566; w[2] = 32'h00778899; w[3] = 32'hFFAABBCC;
        reset = 1'b1; enable = 1'b0; wr_if.wr_valid = 1'b0; wr_if.wr_data = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle("disabled");

        // free-running timing with no data: two frame starts, sync/blank shapes, sticky underflow
        enable = 1'b1; t = -1; auto_chk = 1;
        repeat (72) tick();
        chk("fetch_req_empty", 32'(wr_if.fetch_req), 32'h1);

        // preload four words during vertical blank; wr_ready drops when full
        wr_if.wr_valid = 1'b1; wr_if.wr_data = w[0];
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pre_lvl", 32'(wr_if.fifo_level), 32'(i + 1));
            chk("pre_ready", 32'(wr_if.wr_ready), 32'(i != 3));
            chk("pre_fetch", 32'(wr_if.fetch_req), 32'(i == 0));
            wr_if.wr_data = (i < 3) ? w[i + 1] : 32'hDEADBEEF;
        end
        tick();
        chk("full_hold", 32'(wr_if.fifo_level), 32'h4);
        wr_if.wr_valid = 1'b0;
        while (t < 95) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pre_rgb", 32'(rgb), {8'h0, w[i][23:0]});
            chk("pop_lvl", 32'(wr_if.fifo_level), 32'(3 - i));
            chk("pop_fetch", 32'(wr_if.fetch_req), 32'(i >= 2));
        end

        // streaming: push on each active clock keeps the level steady at two
        wr_if.wr_valid = 1'b1; wr_if.wr_data = dword(0);
        tick();
        chk("str_lvl0", 32'(wr_if.fifo_level), 32'h1);
        wr_if.wr_data = dword(1);
        tick();
        chk("str_lvl1", 32'(wr_if.fifo_level), 32'h2);
        wr_if.wr_valid = 1'b0;
        j = 0; k = 2;
        while (j < 14) begin
            if (k < 14 && is_act(t + 1)) begin
                wr_if.wr_valid = 1'b1; wr_if.wr_data = dword(k); k++;
            end else wr_if.wr_valid = 1'b0;
            tick();
            if (is_act(t)) begin
                chk("str_rgb", 32'(rgb), {8'h0, dword(j)[23:0]});
                j++;
            end
            chk("str_lvl", 32'(wr_if.fifo_level), 32'(k - j));
        end

        // push into empty FIFO on an active clock: no bypass, word shows on the next pixel
        wr_if.wr_valid = 1'b1; wr_if.wr_data = 32'h00E0E0E0;
        tick();
        chk("nobypass_rgb", 32'(rgb), 32'h0);
        chk("nobypass_lvl", 32'(wr_if.fifo_level), 32'h1);
        wr_if.wr_valid = 1'b0;
        tick();
        chk("late_rgb", 32'(rgb), 32'h00E0E0E0);
        chk("late_lvl", 32'(wr_if.fifo_level), 32'h0);

        // fill up again, then drop enable at hcnt=2
        wr_if.wr_valid = 1'b1; wr_if.wr_data = 32'h00ABCDEF;
        while (t < 162) tick();
        chk("pre_drop_lvl", 32'(wr_if.fifo_level), 32'h3);
        enable = 1'b0; auto_chk = 0;
        @(negedge clk);
        check_idle("drop");

        // re-enable with a push on the very first active clock
        wr_if.wr_data = 32'h00C0FFEE; enable = 1'b1; t = 0;
        @(negedge clk);
        chk("reen_flags", 32'(flags), 32'h30);
        chk("reen_rgb", 32'(rgb), 32'h0);
        chk("reen_lvl", 32'(wr_if.fifo_level), 32'h1);
        wr_if.wr_valid = 1'b0; wr_if.wr_data = '0;
        @(negedge clk);
        chk("reen_rgb1", 32'(rgb), 32'h00C0FFEE);
        chk("reen_flags1", 32'(flags), 32'h10);
        chk("reen_lvl1", 32'(wr_if.fifo_level), 32'h0);

        // reset while full with wr_valid held
        wr_if.wr_valid = 1'b1; wr_if.wr_data = 32'h00555555;
        repeat (6) @(negedge clk);
        chk("full_lvl", 32'(wr_if.fifo_level), 32'h4);
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(wr_if.wr_ready), 32'h0);
        @(negedge clk);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_rgb", 32'(rgb), 32'h0);
        chk("rst_lvl", 32'(wr_if.fifo_level), 32'h0);
        reset = 1'b0; wr_if.wr_valid = 1'b0; enable = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
